// File: rtl/instr_fetch_unit.sv
// Y86-64 fetch stage.
// Reads instruction bytes one at a time from a byte-wide instruction memory,
// works out the instruction length from icode, assembles rA/rB/valC, computes
// valP and hands one field bundle per instruction downstream over valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_load, pc_in        redirect strobe and target (highest priority)
//   imem_req, imem_addr   byte read request and address
//   imem_ack, imem_data,
//   imem_err              read completion, byte, address fault
//   out_valid, out_ready  bundle handshake
//   icode, ifun, rA, rB,
//   valC, valP            decoded fields of the presented instruction
//   instr_valid           0 when icode is illegal
//   imem_error            memory fault or timeout during this fetch
//   halted                fetch stopped (halt, illegal or error)
module instr_fetch_unit #(
  parameter int PC_W          = 64,
  parameter int IMEM_MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  input  logic            imem_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [63:0]     valC,
  output logic [PC_W-1:0] valP,
  output logic            instr_valid,
  output logic            imem_error,
  output logic            halted
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_FETCH_REG = 3'd2;
  localparam logic [2:0] S_FETCH_C   = 3'd3;
  localparam logic [2:0] S_PRESENT   = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam int WAIT_W = (IMEM_MAX_WAIT < 2) ? 1 : $clog2(IMEM_MAX_WAIT + 1);

  // Instruction length in bytes as a function of icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  logic [2:0]        state;
  logic [PC_W-1:0]   pc;
  logic [3:0]        off;
  logic [3:0]        len;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        op_len;
  logic [2:0]        c_idx;
  logic              fetching;
  logic              timeout;

  assign fetching  = (state == S_FETCH_OP) || (state == S_FETCH_REG) || (state == S_FETCH_C);
  assign imem_req  = fetching;
  assign imem_addr = pc + PC_W'(off);
  assign out_valid = (state == S_PRESENT);
  assign op_len    = instr_len(imem_data[7:4]);
  // valC bytes start at offset len-8, so (off - len) mod 8 is the byte lane.
  assign c_idx     = off[2:0] - len[2:0];
  assign timeout   = (IMEM_MAX_WAIT != 0) && (wait_cnt == WAIT_W'(IMEM_MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      off         <= '0;
      len         <= '0;
      wait_cnt    <= '0;
      icode       <= '0;
      ifun        <= '0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= '0;
      valP        <= '0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
      halted      <= 1'b0;
    end else if (pc_load) begin
      // Redirect wins over everything, including a same-cycle ack or handshake.
      state       <= S_FETCH_OP;
      pc          <= pc_in;
      off         <= '0;
      len         <= '0;
      wait_cnt    <= '0;
      icode       <= '0;
      ifun        <= '0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= '0;
      valP        <= '0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_FETCH_OP, S_FETCH_REG, S_FETCH_C: begin
          if (imem_ack && !imem_err) begin
            wait_cnt <= '0;
            off      <= off + 4'd1;
            if (state == S_FETCH_OP) begin
              icode       <= imem_data[7:4];
              ifun        <= imem_data[3:0];
              len         <= op_len;
              instr_valid <= (imem_data[7:4] <= 4'hB);
              if (op_len == 4'd1) begin
                valP  <= pc + PC_W'(1);
                state <= S_PRESENT;
              end else if (op_len == 4'd9) begin
                state <= S_FETCH_C;
              end else begin
                state <= S_FETCH_REG;
              end
            end else if (state == S_FETCH_REG) begin
              rA <= imem_data[7:4];
              rB <= imem_data[3:0];
              if (len == 4'd10) begin
                state <= S_FETCH_C;
              end else begin
                valP  <= pc + PC_W'(len);
                state <= S_PRESENT;
              end
            end else begin
              valC[{c_idx, 3'b000} +: 8] <= imem_data;
              if (off == len - 4'd1) begin
                valP  <= pc + PC_W'(len);
                state <= S_PRESENT;
              end
            end
          end else if (imem_ack || timeout) begin
            // Fault or timeout: keep what was fetched, report at the current PC.
            wait_cnt    <= '0;
            instr_valid <= 1'b1;
            imem_error  <= 1'b1;
            valP        <= pc;
            state       <= S_PRESENT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            pc       <= valP;
            off      <= '0;
            wait_cnt <= '0;
            if ((icode == 4'h0) || !instr_valid || imem_error) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              icode       <= '0;
              ifun        <= '0;
              rA          <= 4'hF;
              rB          <= 4'hF;
              valC        <= '0;
              instr_valid <= 1'b0;
              imem_error  <= 1'b0;
              state       <= S_FETCH_OP;
            end
          end
        end
        S_IDLE, S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
